// File: rtl/seq_decimalizer_pkg.sv
// Shared definitions for seq_decimalizer: blank nibble code and FSM state encoding.
package seq_decimalizer_pkg;

  localparam logic [3:0] DECIM_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    STORE = 2'd3
  } decim_state_t;

endpackage

// File: rtl/seq_decimalizer_dd_step.sv
// One double-dabble step: add 3 to every nibble >= 5, then shift left taking in one bit.
module bcd_dd_step #(
  parameter int DIGITS = 3
) (
  input  logic [DIGITS*4-1:0] bcd,
  input  logic                shift_bit,
  output logic [DIGITS*4-1:0] bcd_next,
  output logic                carry
);

  logic [DIGITS*4-1:0] adj_s;

  // Per-nibble add-3 correction followed by the one-bit shift.
  always_comb begin
    adj_s = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) begin
        adj_s[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end else begin
        adj_s[d*4 +: 4] = bcd[d*4 +: 4];
      end
    end
    {carry, bcd_next} = {adj_s, shift_bit};
  end

endmodule

// File: rtl/seq_decimalizer.sv
// Time-shared multi-channel binary-to-BCD converter with saturation on overflow.
// Optional leading-zero blanking is enabled by defining SEQ_DECIMALIZER_LZ_BLANK_EN.
module seq_decimalizer
  import seq_decimalizer_pkg::*;
#(
  parameter int CH     = 6,
  parameter int W_IN   = 8,
  parameter int DIGITS = 3
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     start,
  input  logic [CH*W_IN-1:0]       values_in,
  output logic [CH*DIGITS*4-1:0]   digits_out,
  output logic [CH-1:0]            ovf_out,
  output logic                     busy,
  output logic                     done,
  output logic                     valid
);

  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int STEP_W = $clog2(W_IN + 1);
  localparam int BCD_W  = DIGITS * 4;
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(CH - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(W_IN - 1);

  decim_state_t               state_r, state_s;
  logic [CH-1:0][W_IN-1:0]    snap_r;
  logic [CH_W-1:0]            ch_idx_r;
  logic [W_IN-1:0]            shift_r;
  logic [BCD_W-1:0]           bcd_r, bcd_next_s;
  logic                       carry_s, ovf_r;
  logic [STEP_W-1:0]          step_r;
  logic [CH-1:0][BCD_W-1:0]   digits_r;
  logic [CH-1:0]              ovf_out_r;
  logic                       busy_r, done_r, valid_r;
  logic                       last_store_s;

  // Overflowed channels saturate to all nines and are never blanked.
  function automatic logic [BCD_W-1:0] format_digits(input logic [BCD_W-1:0] bcd,
                                                     input logic ovf);
    logic [BCD_W-1:0] res;
    res = bcd;
    if (ovf) begin
      for (int d = 0; d < DIGITS; d++) res[d*4 +: 4] = 4'd9;
    end else begin
`ifdef SEQ_DECIMALIZER_LZ_BLANK_EN
      begin : g_blank
        logic lead;
        lead = 1'b1;
        for (int d = DIGITS - 1; d > 0; d--) begin
          if (lead && (bcd[d*4 +: 4] == 4'd0)) res[d*4 +: 4] = DECIM_BLANK;
          else lead = 1'b0;
        end
      end
`else
      res = bcd;
`endif
    end
    return res;
  endfunction

  bcd_dd_step #(.DIGITS(DIGITS)) u_step (
    .bcd       (bcd_r),
    .shift_bit (shift_r[W_IN-1]),
    .bcd_next  (bcd_next_s),
    .carry     (carry_s)
  );

  assign last_store_s = (state_r == STORE) && (ch_idx_r == LAST_CH);

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_r <= IDLE;
    else         state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = LOAD; else state_s = IDLE;
      LOAD:    state_s = SHIFT;
      SHIFT:   if (step_r == LAST_STEP) state_s = STORE; else state_s = SHIFT;
      STORE:   if (ch_idx_r == LAST_CH) state_s = IDLE; else state_s = LOAD;
      default: state_s = IDLE;
    endcase
  end

  // Snapshot, conversion datapath and output registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      snap_r    <= '0;
      ch_idx_r  <= '0;
      shift_r   <= '0;
      bcd_r     <= '0;
      ovf_r     <= 1'b0;
      step_r    <= '0;
      digits_r  <= '0;
      ovf_out_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      done_r  <= last_store_s;
      valid_r <= valid_r | last_store_s;
      busy_r  <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (start) begin
            snap_r   <= values_in;
            ch_idx_r <= '0;
          end
        end
        LOAD: begin
          shift_r <= snap_r[ch_idx_r];
          bcd_r   <= '0;
          ovf_r   <= 1'b0;
          step_r  <= '0;
        end
        SHIFT: begin
          bcd_r   <= bcd_next_s;
          shift_r <= shift_r << 1;
          ovf_r   <= ovf_r | carry_s;
          step_r  <= step_r + 1'b1;
        end
        STORE: begin
          digits_r[ch_idx_r]  <= format_digits(bcd_r, ovf_r);
          ovf_out_r[ch_idx_r] <= ovf_r;
          if (ch_idx_r != LAST_CH) ch_idx_r <= ch_idx_r + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign digits_out = digits_r;
  assign ovf_out    = ovf_out_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign valid      = valid_r;

endmodule
